// File: rtl/noc_port_flit_checker.sv
// Per-port NoC flit checker: packet framing, credit occupancy, boundary legality, sticky first error.
// Optional dimension-order route check on headers is compiled in with `define NOC_CHK_ROUTE_EN.
module noc_port_flit_checker #(
  parameter int DATA_WIDTH = 64,
  parameter int NOC_ID     = 1,
  parameter int PORT_DIR   = 0,
  parameter int TILE_X     = 0,
  parameter int TILE_Y     = 0,
  parameter int BOUNDARY   = 0,
  parameter int CREDITS    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flit_valid,
  input  logic [DATA_WIDTH-1:0] flit_data,
  input  logic                  flit_yummy,
  input  logic                  err_clear,
  output logic                  err_valid,
  output logic [2:0]            err_code,
  output logic [31:0]           err_info,
  output logic                  in_packet,
  output logic [3:0]            credits_used,
  output logic [31:0]           pkt_count,
  output logic [31:0]           flit_count
);

  localparam logic [3:0] CRED_MAX = 4'(CREDITS);
  localparam logic [7:0] TX       = 8'(TILE_X);
  localparam logic [7:0] TY       = 8'(TILE_Y);

  localparam logic [2:0] E_NONE  = 3'd0;
  localparam logic [2:0] E_BOUND = 3'd1;
  localparam logic [2:0] E_OVF   = 3'd2;
  localparam logic [2:0] E_UDF   = 3'd3;
  localparam logic [2:0] E_ROUTE = 3'd4;

  typedef enum logic {IDLE, BODY} state_t;

  state_t      state;
  logic [7:0]  remaining;
  logic [7:0]  hdr_len;
  logic [7:0]  dest_x;
  logic [7:0]  dest_y;
  logic        ovf;
  logic        udf;
  logic        route_err;
  logic [2:0]  new_code;
  logic        unused_bits;

  assign hdr_len = flit_data[29:22];
  assign dest_x  = flit_data[49:42];
  assign dest_y  = flit_data[41:34];

  // Only the header fields are inspected; the rest of the flit is deliberately ignored.
  assign unused_bits = ^flit_data;

  assign err_info = {8'(NOC_ID), 8'(PORT_DIR), TY, TX};

`ifdef NOC_CHK_ROUTE_EN
  logic route_ok;

  // X-then-Y routing: a flit leaves E/W only while X still differs, N/S only once X matches.
  always_comb begin
    route_ok = 1'b1;
    case (PORT_DIR)
      0:       route_ok = (dest_x == TX) && (dest_y < TY);
      1:       route_ok = (dest_x == TX) && (dest_y > TY);
      2:       route_ok = (dest_x > TX);
      3:       route_ok = (dest_x < TX);
      default: route_ok = 1'b1;
    endcase
  end

  assign route_err = flit_valid && (state == IDLE) && !route_ok;
`else
  logic unused_route;
  assign unused_route = ^{dest_x, dest_y};
  assign route_err    = 1'b0;
`endif

  assign ovf = flit_valid && !flit_yummy && (credits_used == CRED_MAX);
  assign udf = flit_yummy && !flit_valid && (credits_used == 4'd0);

  always_comb begin
    new_code = E_NONE;
    if ((BOUNDARY != 0) && flit_valid) new_code = E_BOUND;
    else if (route_err)                new_code = E_ROUTE;
    else if (ovf)                      new_code = E_OVF;
    else if (udf)                      new_code = E_UDF;
  end

  // Framing FSM with registered in_packet and packet/flit counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      remaining  <= 8'd0;
      in_packet  <= 1'b0;
      pkt_count  <= 32'd0;
      flit_count <= 32'd0;
    end else if (flit_valid) begin
      flit_count <= flit_count + 32'd1;
      case (state)
        IDLE: begin
          if (hdr_len == 8'd0) begin
            pkt_count <= pkt_count + 32'd1;
          end else begin
            remaining <= hdr_len;
            state     <= BODY;
            in_packet <= 1'b1;
          end
        end
        BODY: begin
          remaining <= remaining - 8'd1;
          if (remaining == 8'd1) begin
            pkt_count <= pkt_count + 32'd1;
            state     <= IDLE;
            in_packet <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_packet <= 1'b0;
        end
      endcase
    end
  end

  // Credit occupancy saturates at both ends; the error path reports the illegal event.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits_used <= 4'd0;
    end else if (flit_valid && !flit_yummy) begin
      if (credits_used != CRED_MAX) credits_used <= credits_used + 4'd1;
    end else if (flit_yummy && !flit_valid) begin
      if (credits_used != 4'd0) credits_used <= credits_used - 4'd1;
    end
  end

  // A new error wins over a simultaneous clear so nothing is lost across a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_valid <= 1'b0;
      err_code  <= E_NONE;
    end else if (err_clear) begin
      err_valid <= (new_code != E_NONE);
      err_code  <= new_code;
    end else if (!err_valid && (new_code != E_NONE)) begin
      err_valid <= 1'b1;
      err_code  <= new_code;
    end
  end

endmodule

// File: doc/noc_port_flit_checker.md
# noc_port_flit_checker

Synthesizable per-port checker placed on one router output port (one NoC, one direction) of a tile, directly upstream of the manycore network monitor. Tracks packet framing from the header payload-length field, credit occupancy from valid/yummy, and boundary legality. Produces a sticky first-error record and packet/flit counters, which the monitor polls instead of probing raw router wires.

## Interface
- `DATA_WIDTH`, 64, flit width; header fields are at fixed bit positions, so only 64 is supported.
- `NOC_ID`, 1, NoC index (1..3), reported in the error record.
- `PORT_DIR`, 0, port direction encoding: 0=N, 1=S, 2=E, 3=W.
- `TILE_X`, 0, X coordinate of the tile owning the port.
- `TILE_Y`, 0, Y coordinate of the tile owning the port.
- `BOUNDARY`, 0, 1 when no valid tile is attached to this port (any flit is illegal).
- `CREDITS`, 4, downstream buffer depth; maximum number of outstanding flits.
- `clk  input  1  clock`
- `rst  input  1  reset, synchronous, active-high`
- `flit_valid  input  1  router out valid`
- `flit_data  input  64  router out data`
- `flit_yummy  input  1  credit return from downstream`
- `err_clear  input  1  clears the sticky error record`
- `err_valid  output  1  sticky error flag`
- `err_code  output  3  first error: 1 boundary, 2 credit overflow, 3 credit underflow, 4 route (macro only)`
- `err_info  output  32  {NOC_ID[7:0], PORT_DIR[7:0], TILE_Y[7:0], TILE_X[7:0]}`; constant, reported for the monitor's message.
- `in_packet  output  1  FSM is in BODY`
- `credits_used  output  4  outstanding flits`
- `pkt_count  output  32  completed packets`
- `flit_count  output  32  total flits`

## Operation
- Header fields: payload length = `flit_data[29:22]`; destX = `[49:42]`; destY = `[41:34]`.
- Framing FSM:
  - IDLE: a valid flit is a header.
    - Length 0: stay in IDLE and increment `pkt_count`.
    - Length n > 0: load `remaining` = n and go to BODY.
  - BODY: each valid flit decrements `remaining`. When the flit arrives with `remaining`==1, increment `pkt_count` and return to IDLE.
  - An 8-bit length of 255 is legal and wraps nothing.
- Flit counter: `flit_count` increments on every valid flit and wraps modulo 2^32. `pkt_count` also wraps.
- Credit counter: `credits_used` += `flit_valid` − `flit_yummy`.
  - Valid and yummy in the same cycle: net 0.
  - Valid while `credits_used`==CREDITS and no yummy: overflow (code 2). The counter saturates at CREDITS.
  - Yummy while `credits_used`==0 and no valid: underflow (code 3). The counter stays at 0.
- Boundary: if BOUNDARY=1, any `flit_valid` raises code 1.
- Error priority within one cycle: 1 > 4 > 2 > 3.
- The first error latches; later errors are ignored until `err_clear`.
- `err_clear` in the same cycle as a new error: the new error latches.
- Checks continue after an error; counters are unaffected by errors.

## Timing
- All outputs are registered. An error on a flit sampled at edge k is visible at `err_valid` after edge k.
- Counters and `in_packet` update on the same edge that samples the flit.
- Reset values:
  - `err_valid`=0, `err_code`=0.
  - `in_packet`=0, `remaining`=0.
  - `credits_used`=0, `pkt_count`=0, `flit_count`=0.
- Reset mid-packet: the FSM returns to IDLE and all counts return to 0. The flit on the reset cycle is ignored.
- `err_clear` takes effect on the next edge: `err_valid`=0, `err_code`=0.

## Configuration
- `NOC_CHK_ROUTE_EN` defined: each header accepted in IDLE is checked for dimension-order (X-then-Y) consistency with PORT_DIR. Any mismatch raises code 4.
  - E requires destX > TILE_X.
  - W requires destX < TILE_X.
  - N requires destX == TILE_X and destY < TILE_Y.
  - S requires destX == TILE_X and destY > TILE_Y.
- Undefined: no route check, and code 4 is never produced.

## Test plan
- Framing: header len=2 plus 2 body flits, then header len=0 (CREDITS=4, yummy returned each cycle) → `pkt_count`=2, `flit_count`=4, `in_packet` high for exactly 2 cycles, `err_valid`=0.
- Overflow: CREDITS=4; 5 consecutive valid flits with no yummy → `err_code`=2 after the 5th flit; `credits_used`=4.
- Underflow and simultaneity: yummy with `credits_used`=0 → code 3. After `err_clear`: valid+yummy together at `credits_used`=4 → no error, count stays at 4.
- Boundary: BOUNDARY=1, NOC_ID=2, PORT_DIR=2; one valid flit → `err_code`=1, `err_info`=0x02020000 (TILE 0,0). A later overflow in the same run does not change `err_code`.
- Reset mid-packet: header len=5, 2 body flits, assert `rst` one cycle → `in_packet`=0 and all counts 0. A new header len=0 is then counted as `pkt_count`=1.
- Route (`NOC_CHK_ROUTE_EN`): PORT_DIR=E, TILE_X=1; header with destX=0 → `err_code`=4. Same header without the macro → no error.
